// File: rtl/clk_timebase_pkg.sv
// Shared constants and BCD helpers for the time-of-day timebase.
package clk_timebase_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 54_000_000;

  // Upper bounds of each BCD time field.
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // A two-digit BCD value is legal when its units digit is a decimal digit
  // and the whole value does not exceed the field limit. With a legal units
  // digit, plain binary ordering matches BCD ordering, so one compare covers
  // the tens digit as well.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Increment a two-digit BCD value; the units digit 9 -> 0 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/clk_timebase_bcd_mod_counter.sv
// Two-digit BCD modulo counter (0 .. MAX) with synchronous load and carry out.
module bcd_mod_counter
  import clk_timebase_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry_out
);

  // Carry fires on the increment that wraps MAX back to zero; a load
  // in the same cycle cancels the increment and therefore the carry.
  assign carry_out = inc & ~load & (value == MAX);

  // Value register: load has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == MAX) ? 8'h00 : bcd_inc(value);
    end
  end

endmodule

// File: rtl/clk_timebase.sv
// Timebase behind the PLL: 1 ms / 1 s ticks, 2 Hz colon blink and a
// 24 h BCD time-of-day with a one-cycle time-set port.
module clk_timebase
  import clk_timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       en,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_err,
  output logic       tick_1ms,
  output logic       tick_1s,
  output logic       blink_2hz,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  localparam int unsigned MS_DIV   = CLK_HZ / 1000;
  localparam int unsigned PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

  logic             lock_p0;
  logic             lock_p1;
  logic             lock_s;
  logic [PRE_W-1:0] presc;
  logic [9:0]       ms;
  logic             run;
  logic             set_ok;
  logic             load;
  logic             ms_edge;
  logic             sec_edge;
  logic             blink_edge;
  logic             ss_carry;
  logic             mm_carry;
  logic             hh_carry_unused;

  // Bring the asynchronous PLL lock into the clk domain (two flops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;
    end
  end

  assign lock_s = lock_p1;
  assign run    = lock_s & en;

  assign set_ok = bcd_in_range(set_hh, HR_MAX) &
                  bcd_in_range(set_mm, MIN_MAX) &
                  bcd_in_range(set_ss, SEC_MAX);
  assign load   = set_valid & set_ok;

  // A valid load restarts the second, so it suppresses any tick due now.
  assign ms_edge    = run & ~load & (presc == PRE_LAST);
  assign sec_edge   = ms_edge & (ms == 10'd999);
  assign blink_edge = ms_edge & ((ms == 10'd499) | (ms == 10'd999));

  // Prescaler, millisecond counter and blink: cleared by a load or loss of
  // lock, frozen while en is low, advanced while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      ms        <= '0;
      blink_2hz <= 1'b0;
    end else if (load || !lock_s) begin
      presc     <= '0;
      ms        <= '0;
      blink_2hz <= 1'b0;
    end else if (run) begin
      presc <= ms_edge ? '0 : presc + 1'b1;
      if (ms_edge) ms <= (ms == 10'd999) ? 10'd0 : ms + 10'd1;
      if (blink_edge) blink_2hz <= ~blink_2hz;
    end
  end

  // Registered one-cycle pulses; they line up with the updated time fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_1ms <= 1'b0;
      tick_1s  <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      tick_1ms <= ms_edge;
      tick_1s  <= sec_edge;
      set_err  <= set_valid & ~set_ok;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sec_edge),
    .load      (load),
    .load_val  (set_ss),
    .value     (ss),
    .carry_out (ss_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ss_carry),
    .load      (load),
    .load_val  (set_mm),
    .value     (mm),
    .carry_out (mm_carry)
  );

  // Hours wrap 23 -> 00 with nothing downstream to carry into.
  bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (mm_carry),
    .load      (load),
    .load_val  (set_hh),
    .value     (hh),
    .carry_out (hh_carry_unused)
  );

endmodule

// File: tb/tb_clk_timebase.sv
// Bench for clk_timebase at CLK_HZ = 10 kHz (10 cycles per millisecond).
module tb_clk_timebase;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int MS_DIV  = CLK_HZ / 1000;
  localparam int SEC_CYC = MS_DIV * 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       en = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic       set_err;
  logic       tick_1ms;
  logic       tick_1s;
  logic       blink_2hz;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: time as seconds of day, position inside the current
  // second as a count of running clock cycles.
  bit m_sh0, m_sh1, m_blink, m_t1ms, m_t1s, m_err;
  int m_phase, m_secs;

  // Observation helpers.
  bit prev_blink;
  int last_rise, period, first_tick;

  always #5 clk = ~clk;

  clk_timebase #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .en        (en),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_err   (set_err),
    .tick_1ms  (tick_1ms),
    .tick_1s   (tick_1s),
    .blink_2hz (blink_2hz),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit decode(input logic [7:0] b, input int limit, output int val);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    val = t * 10 + u;
    return (u <= 9) && (t <= 9) && (val < limit);
  endfunction

  task automatic model_reset();
    m_sh0 = 0; m_sh1 = 0; m_blink = 0; m_t1ms = 0; m_t1s = 0; m_err = 0;
    m_phase = 0; m_secs = 0;
  endtask

  task automatic model_edge();
    bit lock_now, ok_h, ok_m, ok_s;
    int h, m, s;
    if (!rst_n) begin
      model_reset();
    end else begin
      lock_now = m_sh1;
      m_sh1 = m_sh0;
      m_sh0 = pll_lock;
      ok_h = decode(set_hh, 24, h);
      ok_m = decode(set_mm, 60, m);
      ok_s = decode(set_ss, 60, s);
      m_err  = set_valid && !(ok_h && ok_m && ok_s);
      m_t1ms = 0;
      m_t1s  = 0;
      if (set_valid && ok_h && ok_m && ok_s) begin
        m_secs = h * 3600 + m * 60 + s;
        m_phase = 0;
        m_blink = 0;
      end else if (!lock_now) begin
        m_phase = 0;
        m_blink = 0;
      end else if (en) begin
        if (m_phase % MS_DIV == MS_DIV - 1) begin
          m_t1ms = 1;
          if (m_phase / MS_DIV == 499 || m_phase / MS_DIV == 999) m_blink = !m_blink;
        end
        m_phase++;
        if (m_phase == SEC_CYC) begin
          m_phase = 0;
          m_t1s = 1;
          m_secs = (m_secs + 1) % 86400;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [27:0] obs, exp;
    obs = {set_err, tick_1ms, tick_1s, blink_2hz, hh, mm, ss};
    exp = {m_err, m_t1ms, m_t1s, m_blink,
           to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed={err,ms,s,blink,hhmmss}=%h expected=%h", tag, cyc, obs, exp);
    end
    if (errors >= 40) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs("cycle");
    if (tick_1ms && first_tick < 0) first_tick = cyc;
    if (blink_2hz && !prev_blink) begin
      if (last_rise >= 0) period = cyc - last_rise;
      last_rise = cyc;
    end
    prev_blink = blink_2hz;
  endtask

  task automatic pulse_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, h, m, s;
    bit found;
    model_reset();
    prev_blink = 0; last_rise = -1; period = -1; first_tick = -1;

    // Reset state
    #2;
    check_outputs("reset");
    rst_n = 1'b1;
    pll_lock = 1'b1;
    en = 1'b1;

    // Scenario 1: first millisecond and first second after lock
    repeat (SEC_CYC + 20) step();
    expect_eq("first_tick_1ms", first_tick, 12);
    expect_eq("ss_after_1s", {hh, mm, ss}, 24'h000001);

    // Scenario 2: set near midnight and roll over
    pulse_set(8'h23, 8'h59, 8'h58);
    expect_eq("set_load", {hh, mm, ss}, 24'h235958);
    last_rise = -1; period = -1;
    repeat (2 * SEC_CYC + 5) step();
    expect_eq("wrap_midnight", {hh, mm, ss}, 24'h000000);
    expect_eq("blink_period", period, SEC_CYC);

    // Scenario 3: rejected set requests
    pulse_set(8'h24, 8'h00, 8'h00);
    expect_eq("set_err_hh", set_err, 1);
    repeat (30) step();
    pulse_set(8'h12, 8'h60, 8'h00);
    expect_eq("set_err_mm", set_err, 1);
    repeat (30) step();
    pulse_set(8'h12, 8'h00, 8'h1A);
    expect_eq("set_err_ss", set_err, 1);
    repeat (30) step();
    expect_eq("time_after_bad_sets", {hh, mm, ss}, 24'h000000);

    // Scenario 4: lose lock mid-second, then relock
    repeat (1234) step();
    pll_lock = 1'b0;
    repeat (50) step();
    pll_lock = 1'b1;
    first_tick = -1;
    mark = cyc;
    repeat (30) step();
    expect_eq("relock_tick", first_tick - mark, 12);

    // Scenario 5: pause with the prescaler at 4
    found = 0;
    for (int i = 0; i < 3 * MS_DIV && !found; i++) begin
      if (m_phase % MS_DIV == 4) found = 1;
      else step();
    end
    expect_eq("presc_reach_4", found, 1);
    en = 1'b0;
    repeat (37) step();
    en = 1'b1;
    first_tick = -1;
    mark = cyc;
    repeat (10) step();
    expect_eq("resume_tick", first_tick - mark, 6);

    // Scenario 6: set lands on the same edge as a seconds rollover
    pulse_set(8'h00, 8'h00, 8'h59);
    for (int i = 0; i < SEC_CYC + 10 && m_phase != SEC_CYC - 1; i++) step();
    expect_eq("reach_rollover", m_phase, SEC_CYC - 1);
    h = int'($urandom_range(0, 23));
    m = int'($urandom_range(0, 59));
    s = int'($urandom_range(0, 59));
    pulse_set(to_bcd(h), to_bcd(m), to_bcd(s));
    expect_eq("set_wins_no_tick_1s", tick_1s, 0);
    expect_eq("set_wins_time", {hh, mm, ss}, {to_bcd(h), to_bcd(m), to_bcd(s)});

    // Randomized operation: en gaps, lock glitches, valid and garbage sets
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) pll_lock = ~pll_lock;
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          set_hh = to_bcd(int'($urandom_range(0, 23)));
          set_mm = to_bcd(int'($urandom_range(0, 59)));
          set_ss = to_bcd(int'($urandom_range(0, 59)));
        end else begin
          set_hh = 8'($urandom);
          set_mm = 8'($urandom);
          set_ss = 8'($urandom);
        end
        set_valid = 1'b1;
      end
      step();
      set_valid = 1'b0;
    end

    // Asynchronous reset mid-operation with a set pending
    pll_lock = 1'b1;
    en = 1'b1;
    repeat (20) step();
    set_hh = 8'h11; set_mm = 8'h22; set_ss = 8'h33; set_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("async_reset");
    step();
    set_valid = 1'b0;
    rst_n = 1'b1;
    repeat (50) step();
    expect_eq("after_reset_time", {hh, mm, ss}, 24'h000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
